// File: rtl/ssd_p_pkg.sv
// ssd_p shared constants: register map, CTRL field layout, segment table.
package ssd_p_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_LED   = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_VALUE = 4'd1;
    localparam logic [ADDR_W-1:0] ADDR_CTRL  = 4'd2;
    localparam logic [ADDR_W-1:0] ADDR_BLINK = 4'd3;

    localparam logic [DATA_W-1:0] CTRL_RST = 32'h0000_00F0;

    localparam int DP_LSB = 0;
    localparam int EN_LSB = 4;
    localparam int MASK_W = 4;

    // Active-high {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/ssd_p_if.sv
// CPU-side register bus of the ssd_p display peripheral.
interface ssd_p_if;
    import ssd_p_pkg::*;

    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;

    modport master (output wea, addra, dina, input douta);
    modport slave  (input wea, addra, dina, output douta);

endinterface

// File: rtl/ssd_p_hex7seg.sv
// Nibble to active-high seven-segment pattern, full hex alphabet.
module hex7seg
    import ssd_p_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[nib];

endmodule

// File: rtl/ssd_p.sv
// LED + 4-digit seven-segment output peripheral with register readback.
// Optional blink support is compiled in with SSD_P_BLINK_EN.
module ssd_p
    import ssd_p_pkg::*;
#(
    parameter int CNT_W   = 18,
    parameter int BLINK_W = 25
) (
    input  logic       clk,
    input  logic       rst,
    ssd_p_if.slave     bus,
    output logic [7:0] led,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [7:0]        led_q, led_d;
    logic [15:0]       value_q, value_d;
    logic [7:0]        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] douta_q, douta_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        led_out_q, led_out_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        an_q, an_d;

    logic [1:0]        d_idx;
    logic [3:0]        nib;
    logic [6:0]        seg_hi;
    logic [3:0]        en_mask;
    logic [3:0]        dp_mask;
    logic              blink_off;
    logic [15:0]       unused_dina;

    assign unused_dina = bus.dina[31:16];

`ifdef SSD_P_BLINK_EN
    localparam logic [BLINK_W-1:0] BCNT_ONE = 1;

    logic               blink_q, blink_d;
    logic [BLINK_W-1:0] bcnt_q, bcnt_d;

    assign bcnt_d    = bcnt_q + BCNT_ONE;
    assign blink_off = blink_q & bcnt_q[BLINK_W-1];
`else
    logic [BLINK_W-1:0] unused_blink_w;

    assign unused_blink_w = '0;
    assign blink_off      = 1'b0;
`endif

    // Register bank writes; fields outside each register are dropped.
    always_comb begin
        led_d   = led_q;
        value_d = value_q;
        ctrl_d  = ctrl_q;
`ifdef SSD_P_BLINK_EN
        blink_d = blink_q;
`endif
        if (bus.wea) begin
            case (bus.addra)
                ADDR_LED:   led_d   = bus.dina[7:0];
                ADDR_VALUE: value_d = bus.dina[15:0];
                ADDR_CTRL:  ctrl_d  = bus.dina[7:0];
`ifdef SSD_P_BLINK_EN
                ADDR_BLINK: blink_d = bus.dina[0];
`endif
                default: ;
            endcase
        end
    end

    // Readback samples the pre-write contents.
    always_comb begin
        douta_d = '0;
        case (bus.addra)
            ADDR_LED:   douta_d = {24'h0, led_q};
            ADDR_VALUE: douta_d = {16'h0, value_q};
            ADDR_CTRL:  douta_d = {24'h0, ctrl_q};
`ifdef SSD_P_BLINK_EN
            ADDR_BLINK: douta_d = {31'h0, blink_q};
`endif
            default:    douta_d = '0;
        endcase
    end

    assign d_idx   = cnt_q[CNT_W-1 -: 2];
    assign nib     = value_q[{d_idx, 2'b00} +: 4];
    assign en_mask = ctrl_q[EN_LSB +: MASK_W];
    assign dp_mask = ctrl_q[DP_LSB +: MASK_W];

    hex7seg u_hex7seg (
        .nib (nib),
        .seg (seg_hi)
    );

    always_comb begin
        cnt_d     = cnt_q + CNT_ONE;
        an_d      = 4'b1111;
        seg_d     = ~seg_hi;
        dp_d      = ~dp_mask[d_idx];
        led_out_d = led_q;
        if (en_mask[d_idx]) begin
            an_d[d_idx] = 1'b0;
        end
        if (blink_off) begin
            an_d      = 4'b1111;
            led_out_d = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q     <= '0;
            value_q   <= '0;
            ctrl_q    <= CTRL_RST[7:0];
            douta_q   <= '0;
            cnt_q     <= '0;
            led_out_q <= '0;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
            an_q      <= 4'b1111;
        end else begin
            led_q     <= led_d;
            value_q   <= value_d;
            ctrl_q    <= ctrl_d;
            douta_q   <= douta_d;
            cnt_q     <= cnt_d;
            led_out_q <= led_out_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

`ifdef SSD_P_BLINK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            blink_q <= blink_d;
            bcnt_q  <= bcnt_d;
        end
    end
`endif

    assign bus.douta = douta_q;
    assign led       = led_out_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;

endmodule

// File: tb/tb_ssd_p.sv
// Directed testbench for ssd_p with CNT_W=4 and BLINK_W=6.
module tb_ssd_p;

    logic       clk;
    logic       rst;
    logic [7:0] led;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int checks;
    int errors;

    ssd_p_if bus ();

    ssd_p #(.CNT_W(4), .BLINK_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .led (led),
        .seg (seg),
        .dp  (dp),
        .an  (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] v);
        bus.wea   = 1'b1;
        bus.addra = a;
        bus.dina  = v;
        tick();
        bus.wea   = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_rd [4];
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        exp_rd[2] = 32'hF0;
        exp_rd[3] = 32'h0;
        // wea asserted during reset must be ignored
        rst       = 1'b1;
        bus.wea   = 1'b1;
        bus.addra = 4'd0;
        bus.dina  = 32'hFF;
        tick();
        tick();
        bus.wea = 1'b0;
        checks++;
        if (led !== 8'h00) begin
            errors++; $display("FAIL reset_led got %h exp 00", led);
        end
        checks++;
        if (an !== 4'b1111) begin
            errors++; $display("FAIL reset_an got %b exp 1111", an);
        end
        checks++;
        if (seg !== 7'h7F) begin
            errors++; $display("FAIL reset_seg got %h exp 7f", seg);
        end
        checks++;
        if (dp !== 1'b1) begin
            errors++; $display("FAIL reset_dp got %b exp 1", dp);
        end
        checks++;
        if (bus.douta !== 32'h0) begin
            errors++; $display("FAIL reset_douta got %h exp 0", bus.douta);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.addra = 4'(k);
            tick();
            checks++;
            if (bus.douta !== exp_rd[k]) begin
                errors++;
                $display("FAIL reset_reg%0d got %h exp %h",
                         k, bus.douta, exp_rd[k]);
            end
        end
    endtask

    task automatic test_write_read();
        bus.wea   = 1'b1;
        bus.addra = 4'd1;
        bus.dina  = 32'h1234ABCD;
        tick();
        bus.wea = 1'b0;
        checks++;
        if (bus.douta !== 32'h0) begin
            errors++; $display("FAIL rdw_old got %h exp 0", bus.douta);
        end
        tick();
        checks++;
        if (bus.douta !== 32'h0000ABCD) begin
            errors++; $display("FAIL rd_value got %h exp 0000abcd", bus.douta);
        end
    endtask

    task automatic test_led_latency();
        wr(4'd0, 32'h0000003C);
        checks++;
        if (led !== 8'h00) begin
            errors++; $display("FAIL led_early got %h exp 00", led);
        end
        tick();
        checks++;
        if (led !== 8'h3C) begin
            errors++; $display("FAIL led_late got %h exp 3c", led);
        end
    endtask

    task automatic test_scan();
        logic [6:0] seg_tbl [4];
        int         d;
        logic [3:0] exp_an;
        seg_tbl[0] = 7'h40;
        seg_tbl[1] = 7'h79;
        seg_tbl[2] = 7'h24;
        seg_tbl[3] = 7'h30;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wr(4'd1, 32'h00003210);
        for (int k = 2; k <= 21; k++) begin
            tick();
            d      = ((k - 1) >> 2) & 3;
            exp_an = ~(4'b0001 << d);
            checks++;
            if (an !== exp_an || seg !== seg_tbl[d]) begin
                errors++;
                $display("FAIL scan_k%0d got an=%b seg=%h exp an=%b seg=%h",
                         k, an, seg, exp_an, seg_tbl[d]);
            end
        end
    endtask

    task automatic test_masks();
        int         d;
        logic [3:0] exp_an;
        logic       exp_dp;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wr(4'd2, 32'h00000055);
        for (int k = 2; k <= 17; k++) begin
            tick();
            d      = ((k - 1) >> 2) & 3;
            exp_an = (d % 2 == 0) ? ~(4'b0001 << d) : 4'b1111;
            exp_dp = (d % 2 == 0) ? 1'b0 : 1'b1;
            checks++;
            if (an !== exp_an || dp !== exp_dp) begin
                errors++;
                $display("FAIL mask_k%0d got an=%b dp=%b exp an=%b dp=%b",
                         k, an, dp, exp_an, exp_dp);
            end
        end
    endtask

    task automatic test_unimpl();
        logic [3:0]  rd_a [6];
        logic [31:0] rd_e [6];
        rd_a[0] = 4'd9;  rd_e[0] = 32'h0;
        rd_a[1] = 4'd15; rd_e[1] = 32'h0;
        rd_a[2] = 4'd0;  rd_e[2] = 32'hA7;
        rd_a[3] = 4'd1;  rd_e[3] = 32'hBEEF;
        rd_a[4] = 4'd2;  rd_e[4] = 32'h55;
        rd_a[5] = 4'd4;  rd_e[5] = 32'h0;
        wr(4'd0, 32'hFFFFFFA7);
        wr(4'd1, 32'hDEADBEEF);
        wr(4'd9, 32'hFFFFFFFF);
        wr(4'd15, 32'hFFFFFFFF);
        wr(4'd4, 32'hFFFFFFFF);
        for (int k = 0; k < 6; k++) begin
            bus.addra = rd_a[k];
            tick();
            checks++;
            if (bus.douta !== rd_e[k]) begin
                errors++;
                $display("FAIL unimpl_rd%0d got %h exp %h",
                         rd_a[k], bus.douta, rd_e[k]);
            end
        end
    endtask

    task automatic test_blink_reg();
        logic [31:0] exp_b;
`ifdef SSD_P_BLINK_EN
        exp_b = 32'h1;
`else
        exp_b = 32'h0;
`endif
        wr(4'd3, 32'hFFFFFFFF);
        bus.addra = 4'd3;
        tick();
        checks++;
        if (bus.douta !== exp_b) begin
            errors++; $display("FAIL blink_reg got %h exp %h", bus.douta, exp_b);
        end
        wr(4'd3, 32'h0);
    endtask

`ifdef SSD_P_BLINK_EN
    task automatic test_blink();
        logic       off;
        logic [7:0] exp_led;
        logic [3:0] exp_an;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wr(4'd0, 32'h5A);
        wr(4'd3, 32'h1);
        for (int k = 3; k <= 100; k++) begin
            tick();
            off     = (((k - 1) >> 5) & 1) == 1;
            exp_led = off ? 8'h00 : 8'h5A;
            exp_an  = off ? 4'b1111 : ~(4'b0001 << (((k - 1) >> 2) & 3));
            checks++;
            if (led !== exp_led || an !== exp_an) begin
                errors++;
                $display("FAIL blink_k%0d got led=%h an=%b exp led=%h an=%b",
                         k, led, an, exp_led, exp_an);
            end
        end
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.wea   = 1'b0;
        bus.addra = 4'd0;
        bus.dina  = 32'h0;
        test_reset();
        test_write_read();
        test_led_latency();
        test_scan();
        test_masks();
        test_unimpl();
        test_blink_reg();
`ifdef SSD_P_BLINK_EN
        test_blink();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
